sync_filter_edge: RTL and testbench

SYNC_FILTER_EDGE -- requirements
Module: sync_filter_edge

---
 rtl/sync_filter_edge.sv | 102 ++++++++++
 tb/tb_sync_filter_edge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sync_filter_edge.sv
// sync_filter_edge: multi-channel input synchronizer with a per-channel glitch filter
// and registered rise/fall/changed pulses. The filter can be bypassed at run time.
module sync_filter_edge #(
    parameter int unsigned      DEPTH       = 2,
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic             clkIn,
    input  logic             rstNIn,
    input  logic [WIDTH-1:0] DIn,
    input  logic             filtEnIn,
    output logic [WIDTH-1:0] QOut,
    output logic [WIDTH-1:0] riseOut,
    output logic [WIDTH-1:0] fallOut,
    output logic             changedOut
);

    localparam int unsigned CntW = $clog2(FILT_CYCLES + 1);
    // Last count before a differing value is accepted, and the counter's ceiling.
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);
    localparam logic [CntW-1:0] CntSat = CntW'(FILT_CYCLES);

    if (DEPTH < 2 || WIDTH < 1 || FILT_CYCLES < 1) begin : gParamCheck
        $fatal(1, "sync_filter_edge: need DEPTH >= 2, WIDTH >= 1, FILT_CYCLES >= 1");
    end

    // Stage 0 is the metastability-exposed capture flop; stage DEPTH-1 is the usable value.
    (* shreg_extract = "no", async_reg = "true" *)
    logic [DEPTH-1:0][WIDTH-1:0] syncQ;
    logic [WIDTH-1:0]            syncVal;

    logic [WIDTH-1:0][CntW-1:0]  cntQ, cntD;
    logic [WIDTH-1:0]            qQ, qD;
    logic [WIDTH-1:0]            riseQ, riseD;
    logic [WIDTH-1:0]            fallQ, fallD;
    logic                        changedQ, changedD;

    assign syncVal = syncQ[DEPTH-1];

    // Synchronizer chain: plain shift, every stage resets to RST_VAL.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            syncQ <= {DEPTH{RST_VAL}};
        end else begin
            syncQ <= {syncQ[DEPTH-2:0], DIn};
        end
    end

    // Per-channel filter: a differing value must persist FILT_CYCLES edges to be accepted.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            cntD[i] = '0;
            qD[i]   = qQ[i];
            if (filtEnIn) begin
                if (syncVal[i] == qQ[i]) begin
                    cntD[i] = '0;
                end else if (cntQ[i] == CntMax) begin
                    qD[i]   = syncVal[i];
                    cntD[i] = '0;
                end else if (cntQ[i] == CntSat) begin
                    cntD[i] = cntQ[i];
                end else begin
                    cntD[i] = cntQ[i] + 1'b1;
                end
            end else begin
                // Bypass: follow the synchronizer directly and drop any partial count.
                qD[i] = syncVal[i];
            end
        end
    end

    // Edge pulses are computed from the next QOut so they line up with the new level.
    always_comb begin
        riseD    = qD & ~qQ;
        fallD    = ~qD & qQ;
        changedD = |(riseD | fallD);
    end

    // Filtered level, counters and pulse registers.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            cntQ     <= '0;
            qQ       <= RST_VAL;
            riseQ    <= '0;
            fallQ    <= '0;
            changedQ <= 1'b0;
        end else begin
            cntQ     <= cntD;
            qQ       <= qD;
            riseQ    <= riseD;
            fallQ    <= fallD;
            changedQ <= changedD;
        end
    end

    assign QOut       = qQ;
    assign riseOut    = riseQ;
    assign fallOut    = fallQ;
    assign changedOut = changedQ;

endmodule

// File: tb/tb_sync_filter_edge.sv
// Directed bench for sync_filter_edge at DEPTH=2, WIDTH=4, FILT_CYCLES=4, RST_VAL=0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sync_filter_edge;

    logic       clkIn;
    logic       rstNIn;
    logic [3:0] DIn;
    logic       filtEnIn;
    logic [3:0] QOut;
    logic [3:0] riseOut;
    logic [3:0] fallOut;
    logic       changedOut;

    int nChecks = 0;
    int nFails  = 0;

    sync_filter_edge #(
        .DEPTH      (2),
        .WIDTH      (4),
        .FILT_CYCLES(4),
        .RST_VAL    (4'h0)
    ) dut (
        .clkIn     (clkIn),
        .rstNIn    (rstNIn),
        .DIn       (DIn),
        .filtEnIn  (filtEnIn),
        .QOut      (QOut),
        .riseOut   (riseOut),
        .fallOut   (fallOut),
        .changedOut(changedOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check all four outputs after edge k of a scenario.
    task automatic checkAll(input string tag, input int k, input logic [3:0] q,
                            input logic [3:0] r, input logic [3:0] f, input logic c);
        checkVal($sformatf("%s_q_e%0d", tag, k), 32'(QOut), 32'(q));
        checkVal($sformatf("%s_rise_e%0d", tag, k), 32'(riseOut), 32'(r));
        checkVal($sformatf("%s_fall_e%0d", tag, k), 32'(fallOut), 32'(f));
        checkVal($sformatf("%s_chg_e%0d", tag, k), 32'(changedOut), 32'(c));
    endtask

    initial begin
        int riseCnt;
        int fallCnt;
        rstNIn   = 1'b0;
        DIn      = 4'h0;
        filtEnIn = 1'b1;

        // Reset asserted before any clock edge.
        #2;
        checkAll("rst_noclk", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clkIn);
        rstNIn = 1'b1;
        repeat (3) @(negedge clkIn);
        checkAll("post_rst", 3, 4'h0, 4'h0, 4'h0, 1'b0);

        // 0 -> 5 held with filter on: accepted after edge 6.
        DIn = 4'h5;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clkIn);
            checkAll("rise5", k, (k >= 6) ? 4'h5 : 4'h0, (k == 6) ? 4'h5 : 4'h0, 4'h0, k == 6);
        end

        // Back to 0: single fall pulse after edge 6.
        DIn = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clkIn);
            checkAll("fall5", k, (k >= 6) ? 4'h0 : 4'h5, 4'h0, (k == 6) ? 4'h5 : 4'h0, k == 6);
        end

        // DIn[0] high for 3 cycles: rejected.
        for (int k = 1; k <= 12; k++) begin
            DIn = (k <= 3) ? 4'h1 : 4'h0;
            @(negedge clkIn);
            checkAll("glitch3", k, 4'h0, 4'h0, 4'h0, 1'b0);
        end

        // DIn[0] high for 4 cycles: accepted at edge 6, released again at edge 10.
        for (int k = 1; k <= 14; k++) begin
            DIn = (k <= 4) ? 4'h1 : 4'h0;
            @(negedge clkIn);
            checkAll("pulse4", k, (k >= 6 && k <= 9) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0,
                     (k == 10) ? 4'h1 : 4'h0, k == 6 || k == 10);
        end

        // Bypass: 1-cycle DIn[1] pulse shows on QOut for one cycle at edge 3.
        filtEnIn = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            DIn = (k == 1) ? 4'h2 : 4'h0;
            @(negedge clkIn);
            checkAll("bypass", k, (k == 3) ? 4'h2 : 4'h0, (k == 3) ? 4'h2 : 4'h0,
                     (k == 4) ? 4'h2 : 4'h0, k == 3 || k == 4);
        end

        // Asynchronous reset between edges while QOut is non-zero.
        DIn = 4'hF;
        repeat (4) @(negedge clkIn);
        checkVal("bypass_q_f", 32'(QOut), 32'hF);
        #2;
        rstNIn = 1'b0;
        #1;
        checkAll("rst_async", 0, 4'h0, 4'h0, 4'h0, 1'b0);

        // Filter on, DIn held at F: reset after 4 edges, then full latency from release.
        @(negedge clkIn);
        rstNIn   = 1'b1;
        filtEnIn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clkIn);
            checkAll("pre_rst", k, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        rstNIn = 1'b0;
        #1;
        checkAll("rst_mid", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clkIn);
        checkAll("rst_held", 1, 4'h0, 4'h0, 4'h0, 1'b0);
        rstNIn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clkIn);
            checkAll("relF", k, (k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0, k == 6);
        end

        // Return to 0, then DIn[2] toggles every cycle for 10 cycles and is held high.
        DIn = 4'h0;
        repeat (8) @(negedge clkIn);
        checkVal("clear_q", 32'(QOut), 32'h0);
        riseCnt = 0;
        fallCnt = 0;
        for (int k = 0; k < 30; k++) begin
            DIn = (k < 10) ? ((k % 2 == 0) ? 4'h4 : 4'h0) : 4'h4;
            @(negedge clkIn);
            riseCnt += int'(riseOut[2]);
            fallCnt += int'(fallOut[2]);
        end
        checkVal("toggle_rise_cnt", 32'(riseCnt), 32'd1);
        checkVal("toggle_fall_cnt", 32'(fallCnt), 32'd0);
        checkVal("toggle_q", 32'(QOut), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
